mux_16to1: RTL and testbench

MUX_16TO1 -- requirements
Module: mux_16to1

---
 rtl/mux_16to1_pkg.sv | 13 +
 rtl/mux_16to1_mux_4to1.sv | 22 ++
 rtl/mux_16to1.sv | 50 +++++
 tb/tb_mux_16to1.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mux_16to1_pkg.sv
// Shared constants and types for the 16:1 registered bit selector.
package mux_16to1_pkg;

  localparam int N_IN   = 16;
  localparam int SEL_W  = 4;

  // The tree is built from 4:1 leaves, so four leaves cover the 16 inputs.
  localparam int LEAF_W = 4;
  localparam int N_LEAF = N_IN / LEAF_W;

  typedef logic [SEL_W-1:0] sel_t;

endpackage : mux_16to1_pkg

// File: rtl/mux_16to1_mux_4to1.sv
// Purely combinational 4:1 bit selector used as a node of the 16:1 tree.
module mux_4to1
  import mux_16to1_pkg::*;
(
  input  logic [LEAF_W-1:0] d,
  input  logic [1:0]        sel,
  output logic              y
);

  // Plain bit indexing; every sel value is legal, so no default X case exists.
  always_comb begin
    y = 1'b0;
    case (sel)
      2'd0: y = d[0];
      2'd1: y = d[1];
      2'd2: y = d[2];
      2'd3: y = d[3];
      default: y = 1'b0;
    endcase
  end

endmodule : mux_4to1

// File: rtl/mux_16to1.sv
// Registered 16:1 bit selector: a two-level tree of 4:1 muxes feeding one
// output flop and a valid flop. Latency is one clock, throughput one per clock.
module mux_16to1
  import mux_16to1_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  a,
  input  logic [SEL_W-1:0] s,
  input  logic             in_valid,
  output logic             f,
  output logic             out_valid
);

  // First level: each leaf picks one bit of its nibble using s[1:0].
  logic [N_LEAF-1:0] leaf_y;
  // Second level result: the selected bit of a, before registering.
  logic              sel_bit;

  generate
    for (genvar gi = 0; gi < N_LEAF; gi++) begin : g_leaf
      mux_4to1 u_leaf (
        .d   (a[gi*LEAF_W +: LEAF_W]),
        .sel (s[1:0]),
        .y   (leaf_y[gi])
      );
    end
  endgenerate

  // Second level: s[3:2] chooses which nibble's result survives.
  mux_4to1 u_root (
    .d   (leaf_y),
    .sel (s[3:2]),
    .y   (sel_bit)
  );

  // Output flops: reset wins over a simultaneous valid, f holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      f         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        f <= sel_bit;
      end
    end
  end

endmodule : mux_16to1

// File: tb/tb_mux_16to1.sv
// Self-checking bench for mux_16to1: directed steps plus a randomized run,
// compared against a shift-and-mask reference model of the selection rule.
module tb_mux_16to1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [3:0]  s;
  logic        in_valid;
  logic        f;
  logic        out_valid;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: what f/out_valid must hold after the latest edge.
  logic exp_f = 1'b0;
  logic exp_v = 1'b0;

  always #5 clk = ~clk;

  mux_16to1 dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .s         (s),
    .in_valid  (in_valid),
    .f         (f),
    .out_valid (out_valid)
  );

  // Reference rule: the selected bit is a shifted right by s, masked to bit 0.
  function automatic logic ref_bit(input logic [15:0] av, input logic [3:0] sv);
    int unsigned word;
    word = int'(av);
    return ((word >> int'(sv)) & 1) != 0;
  endfunction

  // Compare DUT outputs with the model.
  task automatic check(input string tag);
    vectors++;
    assert (f === exp_f) else begin
      miscompares++;
      $error("FAIL %s f: observed %b expected %b", tag, f, exp_f);
    end
    assert (out_valid === exp_v) else begin
      miscompares++;
      $error("FAIL %s out_valid: observed %b expected %b", tag, out_valid, exp_v);
    end
  endtask

  // Compare DUT outputs with hand-derived constants.
  task automatic expect_const(input string tag, input logic ef, input logic ev);
    vectors++;
    assert (f === ef) else begin
      miscompares++;
      $error("FAIL %s f(const): observed %b expected %b", tag, f, ef);
    end
    assert (out_valid === ev) else begin
      miscompares++;
      $error("FAIL %s out_valid(const): observed %b expected %b", tag, out_valid, ev);
    end
  endtask

  // Drive one cycle of inputs, advance the model on the edge, then check.
  task automatic step(input logic r, input logic iv, input logic [15:0] av,
                      input logic [3:0] sv, input string tag);
    @(negedge clk);
    rst      = r;
    in_valid = iv;
    a        = av;
    s        = sv;
    @(posedge clk);
    if (r) begin
      exp_f = 1'b0;
      exp_v = 1'b0;
    end else if (iv) begin
      exp_f = ref_bit(av, sv);
      exp_v = 1'b1;
    end else begin
      exp_v = 1'b0;
    end
    #1;
    check(tag);
    $display("step %-10s rst=%b iv=%b a=%h s=%h -> f=%b ov=%b", tag, r, iv, av, sv, f, out_valid);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 16'hFFFF;
    s        = 4'h0;

    // Reset held two cycles with valid, all-ones input: outputs stay cleared.
    step(1'b1, 1'b1, 16'hFFFF, 4'h5, "reset0");
    expect_const("reset0", 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'hFFFF, 4'hA, "reset1");
    expect_const("reset1", 1'b0, 1'b0);

    // Directed pattern 16'h3F0A, first edge after reset release has no wait.
    step(1'b0, 1'b1, 16'h3F0A, 4'h0, "dir_s0");
    expect_const("dir_s0", 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h3F0A, 4'h1, "dir_s1");
    expect_const("dir_s1", 1'b1, 1'b1);
    step(1'b0, 1'b1, 16'h3F0A, 4'h6, "dir_s6");
    expect_const("dir_s6", 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h3F0A, 4'hC, "dir_sC");
    expect_const("dir_sC", 1'b1, 1'b1);

    // Walking one: the lit bit is found, its neighbour is not.
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 1'b1, 16'(1 << k), 4'(k), "walk_hit");
      expect_const("walk_hit", 1'b1, 1'b1);
      step(1'b0, 1'b1, 16'(1 << k), 4'((k + 1) % 16), "walk_miss");
      expect_const("walk_miss", 1'b0, 1'b1);
    end

    // Hold: MSB captured, then idle cycles with changing a keep f.
    step(1'b0, 1'b1, 16'h8000, 4'hF, "hold_cap");
    expect_const("hold_cap", 1'b1, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 4'hF, "hold_idle");
    expect_const("hold_idle", 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 4'h0, "hold_idle2");
    expect_const("hold_idle2", 1'b1, 1'b0);

    // Inputs wiggling between edges must not reach f.
    step(1'b0, 1'b1, 16'hFFFF, 4'h7, "glitch_cap");
    a = 16'h0000;
    s = 4'h2;
    #2;
    expect_const("glitch_mid", 1'b1, 1'b1);

    // Reset mid-stream beats a simultaneous valid, then recovery is immediate.
    step(1'b0, 1'b1, 16'hFFFF, 4'h3, "mid_pre");
    expect_const("mid_pre", 1'b1, 1'b1);
    step(1'b1, 1'b1, 16'hFFFF, 4'h3, "mid_rst");
    expect_const("mid_rst", 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'hFFFF, 4'h3, "mid_post");
    expect_const("mid_post", 1'b1, 1'b1);

    // Randomized run: all select values cycled, occasional idle cycles.
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, ($urandom_range(0, 7) != 0), 16'($urandom), 4'(i % 16), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mux_16to1
